// File: rtl/rf_write_arbiter.sv
// Round-robin write arbiter that lets three requesters share one register bank.
// Issues at most one registered one-hot load enable and data word per cycle, and acks the winner.
module rf_write_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [2:0]            req,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [ADDR_WIDTH-1:0] addr2,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [DATA_WIDTH-1:0] wdata2,
    output logic [2:0]            ack,
    output logic                  err,
    output logic [NUM_REGS-1:0]   reg_en,
    output logic [DATA_WIDTH-1:0] reg_d,
    output logic                  busy
);

    logic [1:0]            ptr_q, ptr_d;
    logic [2:0]            ack_q, ack_d;
    logic                  err_q, err_d;
    logic [NUM_REGS-1:0]   reg_en_q, reg_en_d;
    logic [DATA_WIDTH-1:0] reg_d_q, reg_d_d;
    logic                  busy_q, busy_d;

    logic [2:0]            eligible;
    logic [1:0]            ptr_eff;
    logic [1:0]            cand;
    logic                  grant_vld;
    logic [1:0]            win;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  addr_ok;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        ack_d     = '0;
        err_d     = 1'b0;
        reg_en_d  = '0;
        reg_d_d   = reg_d_q;
        cand      = 2'd0;
        grant_vld = 1'b0;
        win       = 2'd0;
        win_addr  = addr2;
        win_data  = wdata2;
        addr_ok   = 1'b0;

        // A requester acked last cycle is still dropping req; mask it to avoid a double grant.
        eligible = req & ~ack_q;
        ptr_eff  = (ptr_q == 2'd3) ? 2'd0 : ptr_q;
        ptr_d    = ptr_eff;

        for (int k = 0; k < 3; k++) begin
            cand = 2'((int'(ptr_eff) + k) % 3);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                win       = cand;
            end
        end

        case (win)
            2'd0: begin
                win_addr = addr0;
                win_data = wdata0;
            end
            2'd1: begin
                win_addr = addr1;
                win_data = wdata1;
            end
            default: begin
                win_addr = addr2;
                win_data = wdata2;
            end
        endcase

        addr_ok = (32'(win_addr) < 32'(NUM_REGS));

        if (grant_vld) begin
            ack_d   = 3'b001 << win;
            reg_d_d = win_data;
            if (addr_ok) begin
                reg_en_d = NUM_REGS'(1) << win_addr;
            end else begin
                err_d = 1'b1;
            end
            ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
        end

        busy_d = |reg_en_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q    <= 2'd0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            reg_en_q <= '0;
            reg_d_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            reg_en_q <= reg_en_d;
            reg_d_q  <= reg_d_d;
            busy_q   <= busy_d;
        end
    end

    assign ack    = ack_q;
    assign err    = err_q;
    assign reg_en = reg_en_q;
    assign reg_d  = reg_d_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a vector table for the main sequence plus hand-written
// sequences for asynchronous reset and the out-of-range address case (3-register instance).
module tb_rf_write_arbiter;

    logic       CLK;
    logic       RST;
    logic [2:0] req;
    logic [1:0] addr0, addr1, addr2;
    logic [3:0] wdata0, wdata1, wdata2;

    logic [2:0] ack, ack3;
    logic       err, err3;
    logic [3:0] reg_en;
    logic [2:0] reg_en3;
    logic [3:0] reg_d, reg_d3;
    logic       busy, busy3;

    int n_checks = 0;
    int n_err    = 0;

    rf_write_arbiter #(.DATA_WIDTH(4), .NUM_REGS(4), .ADDR_WIDTH(2)) dut (
        .CLK(CLK), .RST(RST), .req(req),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .ack(ack), .err(err), .reg_en(reg_en), .reg_d(reg_d), .busy(busy)
    );

    rf_write_arbiter #(.DATA_WIDTH(4), .NUM_REGS(3), .ADDR_WIDTH(2)) dut3 (
        .CLK(CLK), .RST(RST), .req(req),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .ack(ack3), .err(err3), .reg_en(reg_en3), .reg_d(reg_d3), .busy(busy3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [2:0] req;
        logic [1:0] a0, a1, a2;
        logic [3:0] w0, w1, w2;
        logic [2:0] ack;
        logic       err;
        logic [3:0] en;
        logic [3:0] d;
        logic       busy;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic [2:0] rq, input logic [1:0] a0, input logic [1:0] a1,
                                input logic [1:0] a2, input logic [3:0] w0, input logic [3:0] w1,
                                input logic [3:0] w2, input logic [2:0] ak, input logic er,
                                input logic [3:0] en, input logic [3:0] d, input logic bz);
        vec_t v;
        v.req = rq; v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.w0 = w0; v.w1 = w1; v.w2 = w2;
        v.ack = ak; v.err = er; v.en = en; v.d = d; v.busy = bz;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Round-robin from reset: 0,1,2,0,1,2 with data tracking the winner.
        vecs[0]  = mk(3'b111, 2'd0, 2'd1, 2'd3, 4'h3, 4'h6, 4'h9, 3'b001, 1'b0, 4'b0001, 4'h3, 1'b1);
        vecs[1]  = mk(3'b111, 2'd0, 2'd1, 2'd3, 4'h3, 4'h6, 4'h9, 3'b010, 1'b0, 4'b0010, 4'h6, 1'b1);
        vecs[2]  = mk(3'b111, 2'd0, 2'd1, 2'd3, 4'h3, 4'h6, 4'h9, 3'b100, 1'b0, 4'b1000, 4'h9, 1'b1);
        vecs[3]  = mk(3'b111, 2'd0, 2'd1, 2'd3, 4'h3, 4'h6, 4'h9, 3'b001, 1'b0, 4'b0001, 4'h3, 1'b1);
        vecs[4]  = mk(3'b111, 2'd0, 2'd1, 2'd3, 4'h3, 4'h6, 4'h9, 3'b010, 1'b0, 4'b0010, 4'h6, 1'b1);
        vecs[5]  = mk(3'b111, 2'd0, 2'd1, 2'd3, 4'h3, 4'h6, 4'h9, 3'b100, 1'b0, 4'b1000, 4'h9, 1'b1);
        // Idle: reg_d holds.
        vecs[6]  = mk(3'b000, 2'd0, 2'd1, 2'd3, 4'h3, 4'h6, 4'h9, 3'b000, 1'b0, 4'b0000, 4'h9, 1'b0);
        // Single write by requester 1, then masked while req is still high.
        vecs[7]  = mk(3'b010, 2'd0, 2'd2, 2'd3, 4'h3, 4'hA, 4'h9, 3'b010, 1'b0, 4'b0100, 4'hA, 1'b1);
        vecs[8]  = mk(3'b010, 2'd0, 2'd2, 2'd3, 4'h3, 4'hA, 4'h9, 3'b000, 1'b0, 4'b0000, 4'hA, 1'b0);
        // Pointer now at 2: contention 0 vs 2 goes to 2, then 0.
        vecs[9]  = mk(3'b101, 2'd0, 2'd2, 2'd3, 4'h3, 4'hA, 4'h9, 3'b100, 1'b0, 4'b1000, 4'h9, 1'b1);
        vecs[10] = mk(3'b101, 2'd0, 2'd2, 2'd3, 4'h3, 4'hA, 4'h9, 3'b001, 1'b0, 4'b0001, 4'h3, 1'b1);
        // Lone requester 2 (pointer at 1), leaving pointer at 0.
        vecs[11] = mk(3'b100, 2'd0, 2'd2, 2'd0, 4'h3, 4'hA, 4'h5, 3'b100, 1'b0, 4'b0001, 4'h5, 1'b1);
        vecs[12] = mk(3'b000, 2'd0, 2'd2, 2'd0, 4'h3, 4'hA, 4'h5, 3'b000, 1'b0, 4'b0000, 4'h5, 1'b0);
        // Withdrawal: req[2] pulses one cycle while requester 0 wins; it is never granted.
        vecs[13] = mk(3'b101, 2'd1, 2'd2, 2'd2, 4'h7, 4'hA, 4'hC, 3'b001, 1'b0, 4'b0010, 4'h7, 1'b1);
        vecs[14] = mk(3'b000, 2'd1, 2'd2, 2'd2, 4'h7, 4'hA, 4'hC, 3'b000, 1'b0, 4'b0000, 4'h7, 1'b0);
        vecs[15] = mk(3'b000, 2'd1, 2'd2, 2'd2, 4'h7, 4'hA, 4'hC, 3'b000, 1'b0, 4'b0000, 4'h7, 1'b0);

        RST = 1'b1;
        req = '0;
        addr0 = '0; addr1 = '0; addr2 = '0;
        wdata0 = '0; wdata1 = '0; wdata2 = '0;
        tick();
        tick();
        check("reset ack", 32'(ack), 32'h0);
        check("reset err", 32'(err), 32'h0);
        check("reset reg_en", 32'(reg_en), 32'h0);
        check("reset reg_d", 32'(reg_d), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        RST = 1'b0;

        for (int i = 0; i < 16; i++) begin
            req = vecs[i].req;
            addr0 = vecs[i].a0; addr1 = vecs[i].a1; addr2 = vecs[i].a2;
            wdata0 = vecs[i].w0; wdata1 = vecs[i].w1; wdata2 = vecs[i].w2;
            tick();
            check($sformatf("v%0d ack", i), 32'(ack), 32'(vecs[i].ack));
            check($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].err));
            check($sformatf("v%0d reg_en", i), 32'(reg_en), 32'(vecs[i].en));
            check($sformatf("v%0d reg_d", i), 32'(reg_d), 32'(vecs[i].d));
            check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("v%0d ack3", i), 32'(ack3), 32'(vecs[i].ack));
        end

        // Asynchronous reset in the middle of a grant (pointer is at 1 here).
        req = 3'b111;
        addr0 = 2'd0; addr1 = 2'd1; addr2 = 2'd2;
        wdata0 = 4'h1; wdata1 = 4'h2; wdata2 = 4'h4;
        tick();
        check("pre-reset ack", 32'(ack), 32'h2);
        check("pre-reset reg_d", 32'(reg_d), 32'h2);
        #1 RST = 1'b1;
        #1;
        check("async reset ack", 32'(ack), 32'h0);
        check("async reset err", 32'(err), 32'h0);
        check("async reset reg_en", 32'(reg_en), 32'h0);
        check("async reset reg_d", 32'(reg_d), 32'h0);
        check("async reset busy", 32'(busy), 32'h0);
        tick();
        check("held reset ack", 32'(ack), 32'h0);
        RST = 1'b0;
        tick();
        check("post-reset ack", 32'(ack), 32'h1);
        check("post-reset reg_en", 32'(reg_en), 32'h1);
        check("post-reset reg_d", 32'(reg_d), 32'h1);

        // Out-of-range address on the 3-register instance.
        RST = 1'b1;
        #2 RST = 1'b0;
        req = 3'b001;
        addr0 = 2'd3; addr1 = 2'd1; addr2 = 2'd0;
        wdata0 = 4'h7; wdata1 = 4'h5; wdata2 = 4'h0;
        tick();
        check("bad addr ack3", 32'(ack3), 32'h1);
        check("bad addr err3", 32'(err3), 32'h1);
        check("bad addr reg_en3", 32'(reg_en3), 32'h0);
        check("bad addr reg_d3", 32'(reg_d3), 32'h7);
        check("bad addr busy3", 32'(busy3), 32'h0);
        check("good addr err", 32'(err), 32'h0);
        check("good addr reg_en", 32'(reg_en), 32'h8);
        req = 3'b000;
        tick();
        check("after err ack3", 32'(ack3), 32'h0);
        check("after err err3", 32'(err3), 32'h0);
        req = 3'b011;
        addr0 = 2'd0;
        tick();
        check("ptr moved ack3", 32'(ack3), 32'h2);
        check("ptr moved reg_en3", 32'(reg_en3), 32'h2);
        check("ptr moved reg_d3", 32'(reg_d3), 32'h5);
        check("ptr moved err3", 32'(err3), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
